// File: rtl/bsk_prm_bus_master_pkg.sv
// Shared types and constants for the BskPRM parallel bus initiator.
// Phase lengths are loaded into the phase timer as N-1.
package bsk_prm_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    TURN   = 3'd4
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [3:0]  cs;
    logic [1:0]  a;
    logic [15:0] data;
  } req_t;

  localparam logic [3:0] BUS_IDLE_CS = 4'hF;

  // A phase of N clocks starts with N-1 in the down-counter and ends when it reads 0.
  function automatic logic [3:0] phase_load(input int unsigned n);
    return 4'(n - 1);
  endfunction

endpackage

// File: rtl/bsk_prm_bus_master_if.sv
// Request/response port of the bus initiator.
// Handshake: a request transfers on a rising clk edge where req_valid and req_ready are both 1;
// req is held stable while req_valid=1 and req_ready=0. rsp_valid is a one-clock pulse with no back-pressure.
interface bsk_prm_bus_master_if;
  import bsk_prm_bus_pkg::*;

  logic        req_valid;
  logic        req_ready;
  req_t        req;
  logic        rsp_valid;
  logic [15:0] rsp_data;

  // master = the requester (CPU/fabric side), slave = the bus initiator receiving requests
  modport master (output req_valid, output req, input req_ready, input rsp_valid, input rsp_data);
  modport slave  (input req_valid, input req, output req_ready, output rsp_valid, output rsp_data);
endinterface

// File: rtl/bsk_prm_bus_master_phase_timer.sv
// 4-bit loadable down-counter timing each bus phase; done while the count is zero.
module bsk_prm_phase_timer (
  input  logic       clk,
  input  logic       res,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (!res) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign done = (cnt == 4'd0);

endmodule

// File: rtl/bsk_prm_bus_master.sv
// BskPRM bus initiator: one request at a time becomes a SETUP/STROBE/HOLD(/TURN) strobe cycle.
// Bus pins are decoded from the state and latched request only, never from the request inputs.
module bsk_prm_bus_master
  import bsk_prm_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned TURN_CYC   = 2
) (
  input  logic                 clk,
  input  logic                 res,
  bsk_prm_bus_master_if.slave  host,
  output logic [3:0]           cs,
  output logic [1:0]           a,
  output logic                 rd,
  output logic                 wr,
  inout  wire  [15:0]          d,
  output logic                 busy,
  output state_t               dbg_state,
  output logic                 d_oe
);

  state_t      state_q;
  state_t      state_n;
  req_t        req_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_data_q;
  logic        phase_done;
  logic        timer_load;
  logic [3:0]  timer_val;
  logic        req_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (host.req_valid) state_n = SETUP;
      SETUP:   if (phase_done) state_n = STROBE;
      STROBE:  if (phase_done) state_n = HOLD;
      HOLD:    if (phase_done) state_n = (!req_q.wr && TURN_CYC != 0) ? TURN : IDLE;
      TURN:    if (phase_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs: bus pins sit at idle values except while a cycle is in SETUP/STROBE/HOLD
  always_comb begin
    cs        = BUS_IDLE_CS;
    a         = 2'b00;
    rd        = 1'b1;
    wr        = 1'b1;
    d_oe      = 1'b0;
    busy      = 1'b1;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        req_ready = res;
      end
      SETUP, HOLD: begin
        cs   = req_q.cs;
        a    = req_q.a;
        d_oe = req_q.wr;
      end
      STROBE: begin
        cs   = req_q.cs;
        a    = req_q.a;
        d_oe = req_q.wr;
        rd   = req_q.wr;
        wr   = !req_q.wr;
      end
      TURN: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Every phase change reloads the timer with the length of the phase being entered
  always_comb begin
    timer_val = 4'd0;
    case (state_n)
      SETUP:   timer_val = phase_load(SETUP_CYC);
      STROBE:  timer_val = phase_load(STROBE_CYC);
      HOLD:    timer_val = phase_load(HOLD_CYC);
      TURN:    timer_val = phase_load(TURN_CYC);
      default: timer_val = 4'd0;
    endcase
  end

  assign timer_load = (state_n != state_q);

  bsk_prm_phase_timer u_timer (
    .clk      (clk),
    .res      (res),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (phase_done)
  );

  // Request latch and read capture on the final STROBE clock
  always_ff @(posedge clk) begin
    if (!res) begin
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
    end else begin
      rsp_valid_q <= 1'b0;
      if (state_q == IDLE && host.req_valid) begin
        req_q <= host.req;
      end
      if (state_q == STROBE && phase_done && !req_q.wr) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= d;
      end
    end
  end

  assign d              = d_oe ? req_q.data : 16'hzzzz;
  assign host.req_ready = req_ready;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_bsk_prm_bus_master.sv
// Bench for bsk_prm_bus_master: a default-timing and a minimum-timing instance, each on its own
// bus with a small BskPRM board model (VERSION 6'h24, PASSWORD 8'hA6, CS 4'b0111).
module tb_bsk_prm_bus_master;
  import bsk_prm_bus_pkg::*;

  localparam int S0 = 2, T0 = 4, H0 = 1, U0 = 2;
  localparam logic [3:0]  DEV_CS  = 4'b0111;
  localparam logic [15:0] ID_WORD = {8'hA6, 6'h24, 2'b11};
  localparam logic [15:0] COM_T   = 16'h1331;

  typedef struct {
    bit          dut;
    logic        wr;
    logic [3:0]  cs;
    logic [1:0]  a;
    logic [15:0] data;
    bit          chk;
    logic [15:0] exp;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  logic req_valid = 1'b0;
  bit   sel       = 1'b0;
  req_t req_v     = '0;

  bsk_prm_bus_master_if if0 ();
  bsk_prm_bus_master_if if1 ();
  assign if0.req_valid = req_valid && !sel;
  assign if0.req       = req_v;
  assign if1.req_valid = req_valid && sel;
  assign if1.req       = req_v;

  logic [3:0] cs0, cs1;
  logic [1:0] a0, a1;
  logic       rd0, rd1, wr0, wr1, busy0, busy1, oe0, oe1;
  state_t     st0, st1;
  wire [15:0] d0, d1;

  bsk_prm_bus_master u_dut (
    .clk(clk), .res(res), .host(if0.slave), .cs(cs0), .a(a0), .rd(rd0), .wr(wr0),
    .d(d0), .busy(busy0), .dbg_state(st0), .d_oe(oe0)
  );

  bsk_prm_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .TURN_CYC(0)) u_fast (
    .clk(clk), .res(res), .host(if1.slave), .cs(cs1), .a(a1), .rd(rd1), .wr(wr1),
    .d(d1), .busy(busy1), .dbg_state(st1), .d_oe(oe1)
  );

  // Board models: drive bD while selected and Rd low; latch A=10 on the rising Wr edge while still selected
  logic [15:0] dev_reg0 = 16'h0000, dev_reg1 = 16'h0000;
  logic        dev_wl0 = 1'b1, dev_wl1 = 1'b1;
  logic [15:0] dev_rv0, dev_rv1;

  always_comb begin
    case (a0)
      2'b00:   dev_rv0 = COM_T;
      2'b10:   dev_rv0 = dev_reg0;
      2'b11:   dev_rv0 = ID_WORD;
      default: dev_rv0 = 16'h0000;
    endcase
    case (a1)
      2'b00:   dev_rv1 = COM_T;
      2'b10:   dev_rv1 = dev_reg1;
      2'b11:   dev_rv1 = ID_WORD;
      default: dev_rv1 = 16'h0000;
    endcase
  end

  assign d0 = (cs0 == DEV_CS && !rd0) ? dev_rv0 : 16'hzzzz;
  assign d1 = (cs1 == DEV_CS && !rd1) ? dev_rv1 : 16'hzzzz;

  always @(negedge clk) begin
    if (!dev_wl0 && wr0 && cs0 == DEV_CS && a0 == 2'b10) dev_reg0 <= d0;
    if (!dev_wl1 && wr1 && cs1 == DEV_CS && a1 == 2'b10) dev_reg1 <= d1;
    dev_wl0 <= wr0;
    dev_wl1 <= wr1;
  end

  // monitor view of whichever instance is selected
  logic [3:0]  m_cs;
  logic        m_rd, m_wr, m_busy, m_oe, m_ready, m_rsp_valid;
  logic [15:0] m_rsp_data;
  logic [1:0]  m_a;
  state_t      m_state;
  always_comb begin
    m_cs        = sel ? cs1 : cs0;
    m_a         = sel ? a1 : a0;
    m_rd        = sel ? rd1 : rd0;
    m_wr        = sel ? wr1 : wr0;
    m_busy      = sel ? busy1 : busy0;
    m_oe        = sel ? oe1 : oe0;
    m_state     = sel ? st1 : st0;
    m_ready     = sel ? if1.req_ready : if0.req_ready;
    m_rsp_valid = sel ? if1.rsp_valid : if0.rsp_valid;
    m_rsp_data  = sel ? if1.rsp_data : if0.rsp_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: one transaction on the selected instance, monitored for 16 clocks after the handshake
  task automatic do_txn(input int idx, input vec_t v);
    int s, t, h, u;
    int rd_lo = 0, wr_lo = 0, both = 0, rsp_n = 0, rsp_at = 0, idle_at = 0;
    int oe_n = 0, turn_n = 0, rdy_bad = 0, sel_n = 0, cs_bad = 0;
    logic [15:0] got = 16'h0000;
    bit hs = 1'b0;
    string p;
    p = $sformatf("v%0d", idx);
    if (v.dut) begin s = 1; t = 1; h = 1; u = 0; end
    else begin s = S0; t = T0; h = H0; u = U0; end
    @(negedge clk);
    sel = v.dut;
    req_v = '{wr: v.wr, cs: v.cs, a: v.a, data: v.data};
    req_valid = 1'b1;
    #1;
    for (int k = 0; k < 20 && !hs; k++) begin
      if (m_ready) hs = 1'b1;
      else begin @(negedge clk); #1; end
    end
    if (!hs) begin
      check({p, "_handshake_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      if (!m_rd) rd_lo++;
      if (!m_wr) wr_lo++;
      if (!m_rd && !m_wr) both++;
      if (m_rsp_valid) begin
        rsp_n++;
        if (rsp_at == 0) rsp_at = n;
        got = m_rsp_data;
      end
      if (!m_busy && idle_at == 0) idle_at = n;
      if (m_oe) oe_n++;
      if (m_state == TURN) begin
        turn_n++;
        if (m_cs != BUS_IDLE_CS) cs_bad++;
      end
      if (m_busy && m_ready) rdy_bad++;
      if (m_cs == DEV_CS) sel_n++;
      if ((!m_rd || !m_wr) && m_cs != v.cs) cs_bad++;
      @(negedge clk);
    end
    check({p, "_rd_low_clocks"}, rd_lo, v.wr ? 0 : t);
    check({p, "_wr_low_clocks"}, wr_lo, v.wr ? t : 0);
    check({p, "_strobe_overlap"}, both, 0);
    check({p, "_rsp_pulses"}, rsp_n, v.wr ? 0 : 1);
    if (!v.wr) check({p, "_rsp_clock"}, rsp_at, 1 + s + t);
    if (v.chk) check({p, "_rsp_data"}, got, v.exp);
    check({p, "_idle_clock"}, idle_at, v.wr ? 1 + s + t + h : 1 + s + t + h + u);
    check({p, "_bd_drive_clocks"}, oe_n, v.wr ? s + t + h : 0);
    check({p, "_turn_clocks"}, turn_n, v.wr ? 0 : u);
    check({p, "_ready_while_busy"}, rdy_bad, 0);
    check({p, "_dev_select_clocks"}, sel_n, (v.cs == DEV_CS) ? s + t + h : 0);
    check({p, "_cs_bad"}, cs_bad, 0);
  endtask

  task automatic check_idle_bus(input string p);
    check({p, "_cs"}, m_cs, BUS_IDLE_CS);
    check({p, "_a"}, m_a, 2'b00);
    check({p, "_rd"}, m_rd, 1'b1);
    check({p, "_wr"}, m_wr, 1'b1);
    check({p, "_bd_drive"}, m_oe, 1'b0);
    check({p, "_rsp_valid"}, m_rsp_valid, 1'b0);
    check({p, "_busy"}, m_busy, 1'b0);
  endtask

  vec_t vecs[11];

  initial begin
    vec_t rv;
    int hs_n, rdy_bad, both, gap_n, gap_bad, idle_run;
    bit seen_busy, hs_now;

    vecs[0]  = '{1'b0, 1'b1, DEV_CS,  2'd2, 16'h9321, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, DEV_CS,  2'd2, 16'h0000, 1'b1, 16'h9321};
    vecs[2]  = '{1'b0, 1'b0, DEV_CS,  2'd3, 16'h0000, 1'b1, 16'hA693};
    vecs[3]  = '{1'b0, 1'b0, DEV_CS,  2'd0, 16'h0000, 1'b1, 16'h1331};
    vecs[4]  = '{1'b0, 1'b1, DEV_CS,  2'd2, 16'h5AA5, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 1'b0, DEV_CS,  2'd2, 16'h0000, 1'b1, 16'h5AA5};
    vecs[6]  = '{1'b0, 1'b0, 4'b0000, 2'd3, 16'h0000, 1'b0, 16'h0000};
    vecs[7]  = '{1'b0, 1'b1, 4'b0000, 2'd1, 16'hFFFF, 1'b0, 16'h0000};
    vecs[8]  = '{1'b1, 1'b0, DEV_CS,  2'd0, 16'h0000, 1'b1, 16'h1331};
    vecs[9]  = '{1'b1, 1'b1, DEV_CS,  2'd2, 16'hC3C3, 1'b0, 16'h0000};
    vecs[10] = '{1'b1, 1'b0, DEV_CS,  2'd2, 16'h0000, 1'b1, 16'hC3C3};

    // reset state
    res = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_bus("reset");
    check("reset_rsp_data", m_rsp_data, 16'h0000);
    check("reset_ready", m_ready, 1'b0);
    check("reset_state", m_state, IDLE);
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    #1;
    check("post_reset_ready", m_ready, 1'b1);

    for (int i = 0; i < 11; i++) do_txn(i, vecs[i]);

    // back-to-back: valid held high across write A=10, read A=10, read A=11
    sel = 1'b0;
    hs_n = 0; rdy_bad = 0; both = 0; gap_n = 0; gap_bad = 0; idle_run = 0; seen_busy = 1'b0;
    exp_q.delete();
    exp_q.push_back(16'h1111);
    exp_q.push_back(ID_WORD);
    @(negedge clk);
    req_v = '{wr: 1'b1, cs: DEV_CS, a: 2'd2, data: 16'h1111};
    req_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (m_busy && m_ready) rdy_bad++;
      if (!m_rd && !m_wr) both++;
      if (m_rsp_valid) begin
        if (exp_q.size() == 0) check("b2b_extra_rsp", 32'd1, 32'd0);
        else check("b2b_rsp_data", m_rsp_data, exp_q.pop_front());
      end
      if (m_busy) begin
        if (seen_busy && idle_run > 0) begin
          gap_n++;
          if (idle_run != 1) gap_bad++;
        end
        idle_run = 0;
        seen_busy = 1'b1;
      end else if (seen_busy) begin
        idle_run++;
      end
      hs_now = m_ready && req_valid;
      if (hs_now) hs_n++;
      @(negedge clk);
      if (hs_now) begin
        case (hs_n)
          1: req_v = '{wr: 1'b0, cs: DEV_CS, a: 2'd2, data: 16'h0000};
          2: req_v = '{wr: 1'b0, cs: DEV_CS, a: 2'd3, data: 16'h0000};
          default: req_valid = 1'b0;
        endcase
      end
    end
    req_valid = 1'b0;
    check("b2b_handshakes", hs_n, 3);
    check("b2b_rsp_missing", exp_q.size(), 0);
    check("b2b_ready_while_busy", rdy_bad, 0);
    check("b2b_strobe_overlap", both, 0);
    check("b2b_gap_count", gap_n, 2);
    check("b2b_gap_not_one", gap_bad, 0);

    // reset during the STROBE of a write aborts it without touching the board register
    @(negedge clk);
    req_v = '{wr: 1'b1, cs: DEV_CS, a: 2'd2, data: 16'hDEAD};
    req_valid = 1'b1;
    #1;
    check("abort_ready", m_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("abort_pre_wr", m_wr, 1'b0);
    check("abort_pre_bd_drive", m_oe, 1'b1);
    res = 1'b0;
    @(negedge clk);
    #1;
    check_idle_bus("abort");
    check("abort_ready_in_reset", m_ready, 1'b0);
    res = 1'b1;
    repeat (2) @(negedge clk);
    rv = '{1'b0, 1'b0, DEV_CS, 2'd2, 16'h0000, 1'b1, 16'h1111};
    do_txn(11, rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
